// File: rtl/flat_array_serializer.sv
// Serialises a buffered flat ROWS x COLS element array into NUM_BEATS beats of
// ELEMS_PER_BEAT elements each, with a zero-bubble reload on the last beat.
module flat_array_serializer #(
  parameter int unsigned BIT_WIDTH      = 4,
  parameter int unsigned ROWS           = 8,
  parameter int unsigned COLS           = 8,
  parameter int unsigned ELEMS_PER_BEAT = 4,
  localparam int unsigned NUM_BEATS     = ROWS * COLS / ELEMS_PER_BEAT,
  localparam int unsigned BEAT_W        = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [ROWS*COLS*BIT_WIDTH-1:0]      in_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [ELEMS_PER_BEAT*BIT_WIDTH-1:0] out_data,
  output logic                                out_last,
  output logic [BEAT_W-1:0]                   out_beat_idx
);

  localparam int unsigned BEAT_BITS = ELEMS_PER_BEAT * BIT_WIDTH;
  localparam int unsigned VEC_BITS  = ROWS * COLS * BIT_WIDTH;
  localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(NUM_BEATS - 1);

  if ((ROWS * COLS) % ELEMS_PER_BEAT != 0) begin : gen_bad_elems_per_beat
    $error("ROWS*COLS must be an integer multiple of ELEMS_PER_BEAT");
  end

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   cnt_q, cnt_d;
  logic [VEC_BITS-1:0] buf_q, buf_d;
  logic                in_hs, out_hs;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  // A load takes priority: it can only coincide with the final beat's handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    if (in_hs) begin
      buf_d   = in_data;
      cnt_d   = '0;
      state_d = StSend;
    end else if (out_hs) begin
      if (out_last) begin
        cnt_d   = '0;
        state_d = StIdle;
      end else begin
        cnt_d = cnt_q + BEAT_W'(1);
      end
    end
  end

  always_comb begin
    out_valid    = (state_q == StSend);
    out_last     = (state_q == StSend) && (cnt_q == LastBeat);
    out_beat_idx = cnt_q;
    in_ready     = rst_n && ((state_q == StIdle) || (out_last && out_ready));
    out_data     = '0;
    for (int unsigned i = 0; i < NUM_BEATS; i++) begin
      if (cnt_q == BEAT_W'(i)) begin
        out_data = buf_q[i*BEAT_BITS +: BEAT_BITS];
      end
    end
  end

endmodule

// File: tb/tb_flat_array_serializer.sv
// Bench for flat_array_serializer: directed cases on a 2x2/2-per-beat instance,
// randomised scoreboard run on a default-parameter instance.
module tb_flat_array_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Small instance: BIT_WIDTH=4, ROWS=2, COLS=2, ELEMS_PER_BEAT=2
  logic        s_rst_n, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;
  logic [15:0] s_in_data;
  logic [7:0]  s_out_data;
  logic [0:0]  s_idx;

  // Default instance: 64 elements, 4 per beat, 16 beats
  logic         d_rst_n, d_in_valid, d_in_ready, d_out_valid, d_out_ready, d_out_last;
  logic [255:0] d_in_data;
  logic [15:0]  d_out_data;
  logic [3:0]   d_idx;

  flat_array_serializer #(
    .BIT_WIDTH(4), .ROWS(2), .COLS(2), .ELEMS_PER_BEAT(2)
  ) u_small (
    .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_last(s_out_last), .out_beat_idx(s_idx)
  );

  flat_array_serializer u_dflt (
    .clk(clk), .rst_n(d_rst_n), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_data(d_in_data), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_data(d_out_data), .out_last(d_out_last), .out_beat_idx(d_idx)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s_rst_n = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    d_rst_n = 1'b0; d_in_valid = 1'b0; d_in_data = '0; d_out_ready = 1'b0;
    step();
    step();
    checks++;
    if ({s_out_valid, s_out_last, s_idx, s_out_data, s_in_ready} !== 12'h0) begin
      failures++;
      $display("FAIL reset_small: got v=%b l=%b idx=%0d d=%h rdy=%b, want all 0",
               s_out_valid, s_out_last, s_idx, s_out_data, s_in_ready);
    end
    checks++;
    if ({d_out_valid, d_out_last, d_idx, d_out_data, d_in_ready} !== 23'h0) begin
      failures++;
      $display("FAIL reset_dflt: got v=%b l=%b idx=%0d d=%h rdy=%b, want all 0",
               d_out_valid, d_out_last, d_idx, d_out_data, d_in_ready);
    end
    s_rst_n = 1'b1;
    d_rst_n = 1'b1;
    #1;
    checks++;
    if (s_in_ready !== 1'b1 || d_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b/%b, want 1/1", s_in_ready, d_in_ready);
    end
  endtask

  task automatic test_basic();
    s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_data = 16'hDCBA;
    #1;
    checks++;
    if (s_in_ready !== 1'b1) begin
      failures++; $display("FAIL basic_idle_ready: got %b, want 1", s_in_ready);
    end
    step();
    s_in_valid = 1'b0;
    #1;
    checks++;
    if ({s_out_valid, s_out_data, s_idx, s_out_last} !== {1'b1, 8'hBA, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL basic_beat0: got v=%b d=%h idx=%0d l=%b, want v=1 d=ba idx=0 l=0",
               s_out_valid, s_out_data, s_idx, s_out_last);
    end
    step();
    checks++;
    if ({s_out_valid, s_out_data, s_idx, s_out_last} !== {1'b1, 8'hDC, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL basic_beat1: got v=%b d=%h idx=%0d l=%b, want v=1 d=dc idx=1 l=1",
               s_out_valid, s_out_data, s_idx, s_out_last);
    end
    step();
    checks++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_idle: got v=%b rdy=%b, want v=0 rdy=1", s_out_valid, s_in_ready);
    end
  endtask

  task automatic test_backpressure();
    s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_data = 16'hDCBA;
    step();
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({s_out_valid, s_out_data, s_idx, s_in_ready} !== {1'b1, 8'hBA, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v=%b d=%h idx=%0d rdy=%b, want v=1 d=ba idx=0 rdy=0",
                 i, s_out_valid, s_out_data, s_idx, s_in_ready);
      end
      step();
    end
    s_out_ready = 1'b1;
    #1;
    checks++;
    if (s_out_data !== 8'hBA) begin
      failures++; $display("FAIL bp_release: got d=%h, want ba", s_out_data);
    end
    step();
    checks++;
    if ({s_out_valid, s_out_data, s_out_last} !== {1'b1, 8'hDC, 1'b1}) begin
      failures++;
      $display("FAIL bp_beat1: got v=%b d=%h l=%b, want v=1 d=dc l=1",
               s_out_valid, s_out_data, s_out_last);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_beats [4] = '{8'h BA, 8'h DC, 8'h 21, 8'h 43};
    s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_data = 16'hDCBA;
    step();
    s_in_data = 16'h4321;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if ({s_out_valid, s_out_data, s_idx, s_out_last} !==
          {1'b1, exp_beats[k], k[0], k[0]}) begin
        failures++;
        $display("FAIL b2b_beat[%0d]: got v=%b d=%h idx=%0d l=%b, want v=1 d=%h idx=%0d l=%0d",
                 k, s_out_valid, s_out_data, s_idx, s_out_last, exp_beats[k], k % 2, k % 2);
      end
      step();
      if (k == 1) s_in_valid = 1'b0;
    end
    checks++;
    if (s_out_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_end: got v=%b, want 0", s_out_valid);
    end
  endtask

  task automatic test_isolation();
    s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_data = 16'hDCBA;
    step();
    s_in_valid = 1'b0; s_in_data = 16'hFFFF;
    #1;
    checks++;
    if (s_out_data !== 8'hBA) begin
      failures++; $display("FAIL iso_beat0: got %h, want ba", s_out_data);
    end
    step();
    checks++;
    if (s_out_data !== 8'hDC) begin
      failures++; $display("FAIL iso_beat1: got %h, want dc", s_out_data);
    end
    step();
  endtask

  task automatic test_reset_mid();
    s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_data = 16'hDCBA;
    step();
    s_in_valid = 1'b0;
    step();
    s_rst_n = 1'b0;
    #1;
    checks++;
    if (s_in_ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_ready_low: got %b, want 0", s_in_ready);
    end
    step();
    checks++;
    if ({s_out_valid, s_out_data, s_idx, s_out_last} !== 11'h0) begin
      failures++;
      $display("FAIL rstmid_cleared: got v=%b d=%h idx=%0d l=%b, want all 0",
               s_out_valid, s_out_data, s_idx, s_out_last);
    end
    s_rst_n = 1'b1;
    step();
    checks++;
    if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_idle: got rdy=%b v=%b, want rdy=1 v=0", s_in_ready, s_out_valid);
    end
    s_in_valid = 1'b1; s_in_data = 16'h1234;
    step();
    s_in_valid = 1'b0;
    checks++;
    if (s_out_data !== 8'h34 || s_out_valid !== 1'b1) begin
      failures++; $display("FAIL rstmid_beat0: got v=%b d=%h, want v=1 d=34", s_out_valid, s_out_data);
    end
    step();
    checks++;
    if (s_out_data !== 8'h12 || s_out_last !== 1'b1) begin
      failures++; $display("FAIL rstmid_beat1: got d=%h l=%b, want d=12 l=1", s_out_data, s_out_last);
    end
    step();
  endtask

  // Reference: a queue of elements in arrival order; one vector is in flight at most.
  task automatic test_random_default();
    logic [3:0] elems [$];
    int vec_in = 0, beats_out = 0, lasts = 0, cycles = 0;
    bit exp_valid, exp_ready;
    logic [3:0] e;
    while ((vec_in < 1000 || elems.size() != 0) && cycles < 90000) begin
      cycles++;
      d_in_valid  = (vec_in < 1000) && ($urandom_range(3) != 0);
      d_out_ready = ($urandom_range(3) != 0);
      for (int k = 0; k < 8; k++) d_in_data[k*32 +: 32] = $urandom();
      #1;
      exp_valid = (elems.size() != 0);
      exp_ready = (elems.size() == 0) || (elems.size() == 4 && d_out_ready);
      checks++;
      if (d_out_valid !== exp_valid || d_in_ready !== exp_ready) begin
        failures++;
        $display("FAIL rand_hs cyc %0d: got v=%b rdy=%b, want v=%b rdy=%b",
                 cycles, d_out_valid, d_in_ready, exp_valid, exp_ready);
      end
      if (d_out_valid && d_out_ready && elems.size() >= 4) begin
        checks++;
        if (d_idx !== 4'(beats_out % 16) || d_out_last !== (beats_out % 16 == 15)) begin
          failures++;
          $display("FAIL rand_idx beat %0d: got idx=%0d l=%b, want idx=%0d l=%0d",
                   beats_out, d_idx, d_out_last, beats_out % 16, beats_out % 16 == 15);
        end
        for (int j = 0; j < 4; j++) begin
          e = elems.pop_front();
          checks++;
          if (d_out_data[j*4 +: 4] !== e) begin
            failures++;
            $display("FAIL rand_elem beat %0d j %0d: got %h, want %h",
                     beats_out, j, d_out_data[j*4 +: 4], e);
          end
        end
        if (d_out_last) lasts++;
        beats_out++;
      end
      if (d_in_valid && d_in_ready) begin
        for (int n = 0; n < 64; n++) elems.push_back(d_in_data[n*4 +: 4]);
        vec_in++;
      end
      step();
    end
    d_in_valid = 1'b0;
    checks++;
    if (beats_out != 16000 || lasts != 1000) begin
      failures++;
      $display("FAIL rand_totals: got beats=%0d lasts=%0d cycles=%0d, want beats=16000 lasts=1000",
               beats_out, lasts, cycles);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_isolation();
    test_reset_mid();
    test_random_default();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flat_array_serializer.md
FLAT_ARRAY_SERIALIZER -- requirements
Module: flat_array_serializer

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 4, bits per array element.
REQ-002 SHALL have parameter ROWS, default 8, element rows in the flat input vector.
REQ-003 SHALL have parameter COLS, default 8, element columns in the flat input vector.
REQ-004 SHALL have parameter ELEMS_PER_BEAT, default 4, elements emitted per output beat; ROWS*COLS SHALL be an integer multiple of it, and an elaboration error SHALL fire otherwise.
REQ-005 SHALL derive NUM_BEATS = ROWS*COLS/ELEMS_PER_BEAT and BEAT_W = max(1, clog2(NUM_BEATS)).
REQ-006 clk  input  1  sole clock; all state updates on the rising edge.
REQ-007 rst_n  input  1  reset; synchronous, active-low.
REQ-008 in_valid  input  1  in_data holds a complete flattened array.
REQ-009 in_ready  output  1  block can accept a vector this cycle.
REQ-010 in_data  input  ROWS*COLS*BIT_WIDTH  flattened array; element n occupies bits [n*BIT_WIDTH +: BIT_WIDTH].
REQ-011 out_valid  output  1  out_data holds a valid beat.
REQ-012 out_ready  input  1  consumer accepts the current beat.
REQ-013 out_data  output  ELEMS_PER_BEAT*BIT_WIDTH  current beat.
REQ-014 out_last  output  1  current beat is beat NUM_BEATS-1 of its vector.
REQ-015 out_beat_idx  output  BEAT_W  index of the current beat, 0..NUM_BEATS-1.

Function
REQ-016 Input handshake SHALL occur when in_valid and in_ready are both 1 at a rising edge; output handshake SHALL occur when out_valid and out_ready are both 1.
REQ-017 SHALL implement FSM states IDLE and SEND.
REQ-018 IDLE: in_ready=1, out_valid=0; an input handshake SHALL register in_data into an internal buffer, clear the beat counter to 0, and move to SEND.
REQ-019 SEND: out_valid=1; each output handshake SHALL increment the beat counter.
REQ-020 Beat k SHALL carry out_data[j*BIT_WIDTH +: BIT_WIDTH] = buffered element k*ELEMS_PER_BEAT+j, for j = 0..ELEMS_PER_BEAT-1.
REQ-021 out_last SHALL be 1 iff in SEND and beat counter = NUM_BEATS-1; out_beat_idx SHALL equal the beat counter.
REQ-022 in_ready SHALL be 1 in IDLE, and in SEND only when out_last and out_ready are both 1 (combinational from out_ready); it SHALL be 0 otherwise.
REQ-023 On a handshake of the last beat with a simultaneous input handshake, the block SHALL load the new vector, reset the counter to 0, and stay in SEND, giving zero bubble cycles between vectors.
REQ-024 On a handshake of the last beat without an input handshake, the block SHALL return to IDLE.
REQ-025 Latency SHALL be one cycle: the first beat is valid in the cycle after the input handshake.
REQ-026 While out_valid=1 and out_ready=0, out_data, out_last and out_beat_idx SHALL hold stable, and out_valid SHALL not deassert.
REQ-027 in_data SHALL be sampled only at the input handshake; later changes SHALL not affect the beats of the vector in flight.
REQ-028 With NUM_BEATS=1, every beat SHALL be last, and back-to-back vectors SHALL stream one per cycle.
REQ-029 out_data SHALL be driven from the buffer and counter through a multiplexer with no combinational path from in_data.

Reset
REQ-030 When rst_n=0 at a rising edge, the block SHALL enter IDLE, clear the beat counter and buffer to 0, and drive out_valid=0, out_last=0, out_beat_idx=0, out_data=0.
REQ-031 While rst_n=0, in_ready SHALL be 0.
REQ-032 Reset asserted mid-vector SHALL discard the remaining beats; the first cycle after release SHALL be IDLE with in_ready=1.

Verification (BIT_WIDTH=4, ROWS=2, COLS=2, ELEMS_PER_BEAT=2 unless stated)
REQ-033 Basic: hold out_ready=1, load in_data=16'hDCBA -> beat 0 is 8'hBA (idx 0, last 0), then beat 1 is 8'hDC (idx 1, last 1), then IDLE.
REQ-034 Backpressure: out_ready=0 for 3 cycles during beat 0 -> out_data stays 8'hBA and out_valid stays 1; beat 1 follows only after the handshake.
REQ-035 Back-to-back: vectors 16'hDCBA and 16'h4321 offered continuously with out_ready=1 -> beats BA, DC, 21, 43 on 4 consecutive cycles with no gap.
REQ-036 Input isolation: change in_data to 16'hFFFF after the handshake of 16'hDCBA -> beats remain BA, DC.
REQ-037 Reset mid-vector: assert rst_n=0 after beat 0 -> the next cycle has out_valid=0 and out_data=0; after release, in_ready=1 and a new vector 16'h1234 yields 34, 12.
REQ-038 Default parameters, random out_ready and in_valid over 1000 vectors -> scoreboard matches every element in order, and out_last pulses every 16th beat.
